// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/product handshake bundle for seq_multiplier
//
// Signals:
//   in_valid, in_ready      operand handshake (producer -> multiplier)
//   a, b, signed_mode       multiplicand, multiplier, two's-complement select
//   out_valid, out_ready    product handshake (multiplier -> consumer)
//   product                 2*WIDTH-bit result
//   busy                    operation in flight
// Modports: master = operand producer / product consumer, slave = multiplier.

interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add sequential multiplier, signed/unsigned
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_multiplier_if.slave (operand handshake, product handshake, busy)
// One operand bit is consumed per RUN cycle, so a product appears WIDTH
// edges after the accept edge. Signed operands are folded to magnitudes on
// capture and the sign is reapplied when the product is loaded.

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     product_q;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              accept;
  logic              last_step;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (state == RUN) && (cnt == LAST);

  // The most negative value negates to itself in WIDTH bits, which read as
  // unsigned is exactly its magnitude 2^(WIDTH-1).
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) a_mag = ~bus.a + ONE_W;
    if (bus.signed_mode && bus.b[WIDTH-1]) b_mag = ~bus.b + ONE_W;
  end

  // Accumulator is 2*WIDTH wide and the shifted multiplicand never exceeds
  // it, so no carry can be lost.
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) acc_sum = acc + mcand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.product   = product_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      // A zero operand must not yield a negative zero.
      neg    <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) &&
                (a_mag != '0) && (b_mag != '0);
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last_step) begin
        cnt       <= '0;
        product_q <= neg ? (~acc_sum + ONE_P) : acc_sum;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have input in_valid, 1 bit: operands present.
REQ-005 The block SHALL have output in_ready, 1 bit: block can accept operands.
REQ-006 The block SHALL have inputs a and b, WIDTH bits each: multiplicand and multiplier.
REQ-007 The block SHALL have input signed_mode, 1 bit: 1 means a and b are two's complement; 0 means unsigned.
REQ-008 The block SHALL have output out_valid, 1 bit: product available.
REQ-009 The block SHALL have input out_ready, 1 bit: consumer accepts product.
REQ-010 The block SHALL have output product, 2*WIDTH bits: the result, interpreted per the captured signed_mode.
REQ-011 The block SHALL have output busy, 1 bit: high in RUN or DONE.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
  - On accept, a, b and signed_mode are captured; later input changes have no effect.
  - FSM enters RUN; step counter is cleared to 0.
REQ-015 On capture with signed_mode=1, operands SHALL be converted to magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned), and result sign = sign(a) XOR sign(b) SHALL be stored.
REQ-016 In RUN, each edge SHALL process one multiplier bit, LSB first, as one partial-product row:
  - if the bit is 1, add the shifted multiplicand magnitude into the 2*WIDTH accumulator;
  - no carries are lost.
REQ-017 After exactly WIDTH RUN edges, the FSM SHALL enter DONE.
  - On that same edge, product is loaded with the accumulator, two's-complement negated if the stored sign is 1.
  - Counter wraps to 0.
REQ-018 Latency: for an accept on edge k, out_valid SHALL be 1 after edge k+WIDTH.
REQ-019 In DONE, out_valid SHALL be 1.
  - product is held stable until the edge with out_ready=1.
  - That edge returns the FSM to IDLE with out_valid=0.
REQ-020 out_valid and in_ready SHALL never be 1 simultaneously; at most one operation is in flight.
REQ-021 in_valid asserted during RUN or DONE SHALL be ignored; no operands are captured.
REQ-022 A zero multiplier or multiplicand SHALL still take WIDTH cycles and yield product 0, with no negative zero (sign forced 0 when the magnitude is 0).
REQ-023 Full-range results SHALL be exact:
  - unsigned (2^WIDTH-1)^2;
  - signed (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2);
  - signed (-2^(WIDTH-1))*(2^(WIDTH-1)-1).
REQ-024 product SHALL retain its last value after return to IDLE until the next DONE entry.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, independent of clk:
  - enter IDLE;
  - clear accumulator, counter and stored sign;
  - drive out_valid=0, product=0, busy=0.
REQ-026 in_ready SHALL be 1 during and after reset.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no product delivered; the first accept after release restarts cleanly.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> out_valid after edge k+4, product=8'hE1 (225).
  - WIDTH=4, signed, a=4'b1000 (-8), b=4'b0111 (7) -> product=8'hC8 (-56); a=-8, b=-8 -> product=8'h40 (64).
  - WIDTH=8, signed, a=0, b=-1 -> product=16'h0000 after 8 RUN cycles.
  - WIDTH=8, a=200, b=3 unsigned, out_ready=0 for 5 cycles:
    - product=16'h0258 held stable, out_valid=1 and in_ready=0 throughout;
    - in_valid pulsed with new operands during the hold is ignored;
    - out_ready=1 -> IDLE next edge.
  - WIDTH=8, rst_n pulsed low at RUN step 3 -> out_valid=0, product=0, in_ready=1 immediately; next accept of a=2, b=3 -> product=6.
  - Back-to-back: accept on the cycle after out_ready handshake -> second result correct with latency WIDTH.
